// File: rtl/des_fsmd_param_if.sv
// Load/result bus between a block source and des_fsmd_param.
// DES_KEY_PARITY_CHECK_EN adds the key_err signal.
interface des_fsmd_param_if #(
  parameter int unsigned IN_W = 32
);
  logic [IN_W:1] msg;
  logic          ready;
  logic [64:1]   key;
  logic          decrypt;
  logic          read;
  logic [64:1]   enc_msg;
  logic          done;
  logic          busy;
`ifdef DES_KEY_PARITY_CHECK_EN
  logic          key_err;

  modport master (output msg, ready, key, decrypt,
                  input  read, enc_msg, done, busy, key_err);
  modport slave  (input  msg, ready, key, decrypt,
                  output read, enc_msg, done, busy, key_err);
`else
  modport master (output msg, ready, key, decrypt,
                  input  read, enc_msg, done, busy);
  modport slave  (input  msg, ready, key, decrypt,
                  output read, enc_msg, done, busy);
`endif
endinterface

// File: rtl/des_fsmd_param.sv
// Iterative DES encrypt/decrypt FSMD: loads a 64-bit block in 64/IN_W parts, one round per clock.
// Optional feature macro: DES_KEY_PARITY_CHECK_EN (odd-parity key check, key_err output).
module des_fsmd_param #(
  parameter int unsigned IN_W = 32
) (
  input logic             clk,
  input logic             rst,
  des_fsmd_param_if.slave bus
);
  localparam int unsigned PARTS  = 64 / IN_W;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned RND_W  = 5;
  localparam int unsigned HOLD_W = (PARTS > 1) ? 64 - IN_W : 1;

  if (IN_W != 16 && IN_W != 32 && IN_W != 64) begin : g_bad_in_w
    $error("des_fsmd_param: IN_W must be 16, 32 or 64");
  end

  localparam int unsigned IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int unsigned FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int unsigned PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int unsigned PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int unsigned E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int unsigned P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // S-box entry (row*16 + col) is the nibble counted from the MSB.
  localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
  localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  // Table bit n (1 = MSB) maps to vector index WIDTH-n.
  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [63:0] fp_f(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [55:0] pc1_f(input logic [63:0] x);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] pc2_f(input logic [55:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [47:0] e_f(input logic [31:0] x);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return o;
  endfunction

  function automatic logic [31:0] p_f(input logic [31:0] x);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return o;
  endfunction

  function automatic logic [3:0] sbox_f(input logic [255:0] t, input logic [5:0] b);
    logic [5:0] idx;
    idx = {b[5], b[0], b[4:1]};
    return 4'(t >> {~idx, 2'b00});
  endfunction

  function automatic logic [31:0] feistel_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    x = e_f(r) ^ k;
    return p_f({sbox_f(S1, x[47:42]), sbox_f(S2, x[41:36]), sbox_f(S3, x[35:30]),
                sbox_f(S4, x[29:24]), sbox_f(S5, x[23:18]), sbox_f(S6, x[17:12]),
                sbox_f(S7, x[11:6]),  sbox_f(S8, x[5:0])});
  endfunction

  typedef enum logic [1:0] {S_LOAD, S_ROUND, S_DONE} state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  part_q, part_n;
  logic [RND_W-1:0]  rnd_q, rnd_n;
  logic [HOLD_W-1:0] hold_q, hold_n, hold_in;
  logic [31:0]       l_q, l_n, r_q, r_n;
  logic [27:0]       c_q, c_n, d_q, d_n, c_rot, d_rot;
  logic [47:0]       subkey;
  logic [63:0]       blk_in, key0, enc_q, enc_n;
  logic              dec_q, dec_n, rdy_q;
  logic              read_q, read_n, done_q, done_n, busy_q, busy_n;
  logic              accept, first, last, one_step;

  assign key0   = bus.key;
  assign accept = bus.ready & ~rdy_q & (state_q == S_LOAD);
  assign first  = (part_q == '0);
  assign last   = (part_q == CNT_W'(PARTS - 1));

  // Earlier parts sit in hold_q; the incoming part completes the low end of the block.
  if (PARTS > 1) begin : g_multi
    assign blk_in  = {hold_q, bus.msg};
    assign hold_in = blk_in[HOLD_W-1:0];
  end else begin : g_single
    assign blk_in  = bus.msg;
    assign hold_in = hold_q;
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic kerr_q, kerr_n, key_ok;

  always_comb begin : parity_chk
    key_ok = 1'b1;
    for (int b = 0; b < 8; b++) key_ok = key_ok & (^8'(key0 >> (8 * b)));
  end

  assign bus.key_err = kerr_q;
`endif

  assign one_step = (rnd_q == RND_W'(0)) || (rnd_q == RND_W'(1)) ||
                    (rnd_q == RND_W'(8)) || (rnd_q == RND_W'(15));

  // Encrypt rotates left before PC-2; decrypt walks the schedule backwards from C0/D0.
  always_comb begin : key_sched
    c_rot = c_q;
    d_rot = d_q;
    if (!dec_q) begin
      if (one_step) begin
        c_rot = {c_q[26:0], c_q[27]};
        d_rot = {d_q[26:0], d_q[27]};
      end else begin
        c_rot = {c_q[25:0], c_q[27:26]};
        d_rot = {d_q[25:0], d_q[27:26]};
      end
    end else if (rnd_q != '0) begin
      if (one_step) begin
        c_rot = {c_q[0], c_q[27:1]};
        d_rot = {d_q[0], d_q[27:1]};
      end else begin
        c_rot = {c_q[1:0], c_q[27:2]};
        d_rot = {d_q[1:0], d_q[27:2]};
      end
    end
    subkey = pc2_f({c_rot, d_rot});
  end

  always_comb begin : fsm_next
    state_n = state_q;
    part_n  = part_q;
    rnd_n   = rnd_q;
    hold_n  = hold_q;
    l_n     = l_q;
    r_n     = r_q;
    c_n     = c_q;
    d_n     = d_q;
    dec_n   = dec_q;
    read_n  = 1'b0;
    done_n  = 1'b0;
    busy_n  = busy_q;
    enc_n   = enc_q;
`ifdef DES_KEY_PARITY_CHECK_EN
    kerr_n  = 1'b0;
`endif
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          read_n = 1'b1;
          hold_n = hold_in;
          part_n = part_q + CNT_W'(1);
          if (first) begin
            dec_n      = bus.decrypt;
            {c_n, d_n} = pc1_f(key0);
            busy_n     = 1'b1;
          end
          if (last) begin
            {l_n, r_n} = ip_f(blk_in);
            part_n     = '0;
            rnd_n      = '0;
            state_n    = S_ROUND;
          end
`ifdef DES_KEY_PARITY_CHECK_EN
          if (first && !key_ok) begin
            kerr_n  = 1'b1;
            busy_n  = 1'b0;
            part_n  = '0;
            state_n = S_LOAD;
          end
`endif
        end
      end
      S_ROUND: begin
        // rnd_q 0..15 run the rounds; the 17th cycle swaps halves and applies FP.
        if (rnd_q != RND_W'(16)) begin
          c_n   = c_rot;
          d_n   = d_rot;
          l_n   = r_q;
          r_n   = l_q ^ feistel_f(r_q, subkey);
          rnd_n = rnd_q + RND_W'(1);
        end else begin
          enc_n   = fp_f({r_q, l_q});
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_LOAD;
        part_n  = '0;
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (!rst) begin
      state_q <= S_LOAD;
      part_q  <= '0;
      rnd_q   <= '0;
      hold_q  <= '0;
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      dec_q   <= 1'b0;
      rdy_q   <= 1'b1;
      read_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      enc_q   <= '0;
`ifdef DES_KEY_PARITY_CHECK_EN
      kerr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      part_q  <= part_n;
      rnd_q   <= rnd_n;
      hold_q  <= hold_n;
      l_q     <= l_n;
      r_q     <= r_n;
      c_q     <= c_n;
      d_q     <= d_n;
      dec_q   <= dec_n;
      rdy_q   <= bus.ready;
      read_q  <= read_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
      enc_q   <= enc_n;
`ifdef DES_KEY_PARITY_CHECK_EN
      kerr_q  <= kerr_n;
`endif
    end
  end

  assign bus.read    = read_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.enc_msg = enc_q;
endmodule
